// File: rtl/issue_ctrl_pkg.sv
// Shared decoder class codes, issue FSM encoding and target-select helper.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package issue_ctrl_pkg;

    localparam logic [1:0] TP_BR  = 2'd0;
    localparam logic [1:0] TP_ST  = 2'd1;
    localparam logic [1:0] TP_LD  = 2'd2;
    localparam logic [1:0] TP_ALU = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } issue_state_t;

    // Memory ops go to the load/store buffer, everything else to the RS.
    function automatic logic tp_is_mem(input logic [1:0] tp);
        case (tp)
            TP_ST, TP_LD:  return 1'b1;
            TP_BR, TP_ALU: return 1'b0;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Fetch/decode/resource bundle around the issue controller.
// Latency: n/a (wiring only).
// Backpressure: fetch holds its offer while if_rdy_o is low.
interface issue_ctrl_if #(
    parameter int DAT_W = 32,
    parameter int CNT_W = 16
);
    logic             en;
    logic             flush_i;
    logic             if_en_i;
    logic             if_ic_i;
    logic [DAT_W-1:0] if_ins_i;
    logic [DAT_W-1:0] if_pc_i;
    logic             if_pbr_i;
    logic             if_rdy_o;
    logic             dec_en_o;
    logic             dec_ic_o;
    logic [DAT_W-1:0] dec_ins_o;
    logic [DAT_W-1:0] dec_pc_o;
    logic             dec_pbr_o;
    logic [1:0]       dec_tp_i;
    logic             rob_full_i;
    logic             rs_full_i;
    logic             lsb_full_i;
    logic             rs_sel_o;
    logic             lsb_sel_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output en, flush_i, if_en_i, if_ic_i, if_ins_i, if_pc_i, if_pbr_i,
               dec_tp_i, rob_full_i, rs_full_i, lsb_full_i,
        input  if_rdy_o, dec_en_o, dec_ic_o, dec_ins_o, dec_pc_o, dec_pbr_o,
               rs_sel_o, lsb_sel_o, stall_cnt_o
    );

    modport slave (
        input  en, flush_i, if_en_i, if_ic_i, if_ins_i, if_pc_i, if_pbr_i,
               dec_tp_i, rob_full_i, rs_full_i, lsb_full_i,
        output if_rdy_o, dec_en_o, dec_ic_o, dec_ins_o, dec_pc_o, dec_pbr_o,
               rs_sel_o, lsb_sel_o, stall_cnt_o
    );
endinterface

// File: rtl/issue_fifo.sv
// Circular buffer with push/pop/clear; head is combinational, zero when empty.
// Latency: push visible at head one edge later.
// Backpressure: caller must not push when full unless popping on the same edge.
module issue_fifo #(
    parameter int  W     = 66,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr,
    input  logic [W-1:0]  push_dat,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/issue_ctrl.sv
// Buffers fetched instructions and issues the head to decode when ROB and target RS/LSB have room.
// Latency: 1 cycle fetch-to-issue, one issue per cycle max.
// Backpressure: if_rdy_o from registered occupancy/state only; rob/rs/lsb full stalls the head.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int DAT_W     = 32,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    issue_ctrl_if.slave bus
);
    localparam int FCNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic             ic;
        logic [DAT_W-1:0] ins;
        logic [DAT_W-1:0] pc;
        logic             pbr;
    } ent_t;

    ent_t              push_ent;
    ent_t              head_ent;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              empty;
    logic              full;
    issue_state_t      state;
    logic              tgt_lsb;
    logic              tgt_free;
    logic              if_rdy;
    logic              issue;
    logic              push;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    assign empty    = (fifo_cnt == '0);
    assign full     = (fifo_cnt == FCNT_W'(BUF_DEPTH));
    assign tgt_lsb  = tp_is_mem(bus.dec_tp_i);
    assign tgt_free = tgt_lsb ? !bus.lsb_full_i : !bus.rs_full_i;

    // rst gating keeps fetch quiet while the block is held in reset.
    assign if_rdy = rst && !full && (state != ST_FLUSH);
    assign issue  = !empty && bus.en && !bus.flush_i && (state != ST_FLUSH)
                    && !bus.rob_full_i && tgt_free;
    assign push   = bus.if_en_i && if_rdy && bus.en && !bus.flush_i;
    assign stall  = !empty && bus.en && !bus.flush_i && !issue;

    assign push_ent = '{ic: bus.if_ic_i, ins: bus.if_ins_i, pc: bus.if_pc_i, pbr: bus.if_pbr_i};

    issue_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (issue),
        .clr      (bus.flush_i),
        .push_dat (push_ent),
        .head_dat (head_ent),
        .count    (fifo_cnt)
    );

    // Flush wins over en; otherwise en low freezes the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else if (bus.flush_i) begin
            state <= ST_FLUSH;
        end else if (bus.en) begin
            case (state)
                ST_RUN:   if (stall) state <= ST_HOLD;
                ST_HOLD:  if (issue || empty) state <= ST_RUN;
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.if_rdy_o    = if_rdy;
    assign bus.dec_en_o    = issue;
    assign bus.rs_sel_o    = issue && !tgt_lsb;
    assign bus.lsb_sel_o   = issue && tgt_lsb;
    assign bus.dec_ic_o    = head_ent.ic;
    assign bus.dec_ins_o   = head_ent.ins;
    assign bus.dec_pc_o    = head_ent.pc;
    assign bus.dec_pbr_o   = head_ent.pbr;
    assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed and randomized bench for issue_ctrl against a queue-based model of the issue rules.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam int DAT_W     = 32;
    localparam int BUF_DEPTH = 4;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct {
        logic             ic;
        logic [DAT_W-1:0] ins;
        logic [DAT_W-1:0] pc;
        logic             pbr;
    } ent_s;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ent_s q[$];
    int   stall_m  = 0;
    bit   in_flush = 1'b0;
    bit   accepted = 1'b0;
    int   n_iss    = 0;
    int   n_lsb    = 0;
    logic [DAT_W-1:0] next_pc = 32'h1000;

    always #5 clk = ~clk;

    issue_ctrl_if #(.DAT_W(DAT_W), .CNT_W(CNT_W)) bus ();

    issue_ctrl #(.DAT_W(DAT_W), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [DAT_W-1:0] pc);
        bus.if_en_i  = 1'b1;
        bus.if_pc_i  = pc;
        bus.if_ins_i = $urandom;
        bus.if_ic_i  = 1'($urandom_range(0, 1));
        bus.if_pbr_i = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge with inputs applied; checks outputs, advances the model, returns at the next negedge.
    task automatic cycle();
        ent_s h;
        bit   lsb, iss, rdy, push;
        #1;
        rdy = (q.size() < BUF_DEPTH) && !in_flush;
        h   = '{1'b0, '0, '0, 1'b0};
        if (q.size() > 0) h = q[0];
        lsb = (bus.dec_tp_i == TP_ST) || (bus.dec_tp_i == TP_LD);
        iss = (q.size() > 0) && bus.en && !bus.flush_i && !in_flush && !bus.rob_full_i
              && (lsb ? !bus.lsb_full_i : !bus.rs_full_i);
        chk("if_rdy",    bus.if_rdy_o,    rdy);
        chk("dec_en",    bus.dec_en_o,    iss);
        chk("rs_sel",    bus.rs_sel_o,    iss && !lsb);
        chk("lsb_sel",   bus.lsb_sel_o,   iss && lsb);
        chk("dec_ic",    bus.dec_ic_o,    h.ic);
        chk("dec_ins",   bus.dec_ins_o,   h.ins);
        chk("dec_pc",    bus.dec_pc_o,    h.pc);
        chk("dec_pbr",   bus.dec_pbr_o,   h.pbr);
        chk("stall_cnt", bus.stall_cnt_o, stall_m);
        chk("fifo_cnt",  dut.fifo_cnt,    q.size());
        n_iss += int'(bus.dec_en_o === 1'b1);
        n_lsb += int'(bus.lsb_sel_o === 1'b1);
        push = bus.if_en_i && rdy && bus.en && !bus.flush_i;
        accepted = push;
        if (bus.flush_i) begin
            q.delete();
            in_flush = 1'b1;
        end else if (bus.en) begin
            if ((q.size() > 0) && !iss && (stall_m < CNT_MAX)) stall_m++;
            if (iss) void'(q.pop_front());
            if (push) q.push_back('{bus.if_ic_i, bus.if_ins_i, bus.if_pc_i, bus.if_pbr_i});
            in_flush = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        bus.en = 1'b1;      bus.flush_i = 1'b0;   bus.if_en_i = 1'b0;
        bus.if_ic_i = 1'b0; bus.if_ins_i = '0;    bus.if_pc_i = '0;   bus.if_pbr_i = 1'b0;
        bus.dec_tp_i = TP_ALU;
        bus.rob_full_i = 1'b0; bus.rs_full_i = 1'b0; bus.lsb_full_i = 1'b0;

        // Reset state
        #2;
        chk("rst_rdy",    bus.if_rdy_o,    0);
        chk("rst_dec_en", bus.dec_en_o,    0);
        chk("rst_stall",  bus.stall_cnt_o, 0);
        chk("rst_pc",     bus.dec_pc_o,    0);
        @(negedge clk);
        rst = 1'b1;

        // Three back-to-back ALU instructions
        n_iss = 0;
        for (int i = 0; i < 3; i++) begin
            offer(DAT_W'(i * 4));
            cycle();
        end
        bus.if_en_i = 1'b0;
        run(2);
        chk("alu_issues", n_iss, 3);
        chk("alu_stall",  bus.stall_cnt_o, 0);

        // Load blocked by a full LSB for five cycles
        bus.dec_tp_i   = TP_LD;
        bus.lsb_full_i = 1'b1;
        offer(32'h10);
        cycle();
        bus.if_en_i = 1'b0;
        run(5);
        chk("ld_stall", bus.stall_cnt_o, 5);
        chk("ld_hold",  dut.state, ST_HOLD);
        bus.lsb_full_i = 1'b0;
        n_lsb = 0;
        cycle();
        chk("ld_issue_lsb", n_lsb, 1);

        // Fill with ROB full; fifth offer must be held
        bus.dec_tp_i   = TP_ALU;
        bus.rob_full_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(DAT_W'(i * 4));
            cycle();
        end
        offer(32'h10);
        cycle();
        chk("full_rdy", bus.if_rdy_o, 0);
        chk("full_cnt", dut.fifo_cnt, 4);

        // Drain while the held offer lands, wrapping the pointers
        bus.rob_full_i = 1'b0;
        n_iss = 0;
        for (int k = 0; k < 4 && !accepted; k++) cycle();
        bus.if_en_i = 1'b0;
        run(5);
        chk("drain_issues", n_iss, 5);

        // Flush with three entries buffered
        bus.rob_full_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(32'h20 + DAT_W'(i * 4));
            cycle();
        end
        bus.if_en_i = 1'b0;
        bus.flush_i = 1'b1;
        cycle();
        bus.flush_i = 1'b0;
        chk("fl_cnt", dut.fifo_cnt, 0);
        chk("fl_rdy", bus.if_rdy_o, 0);
        n_iss = 0;
        bus.rob_full_i = 1'b0;
        offer(32'h100);
        for (int k = 0; k < 4 && !accepted; k++) cycle();
        bus.if_en_i = 1'b0;
        cycle();
        chk("fl_post_issue", n_iss, 1);

        // Stall with en low for three cycles
        bus.rob_full_i = 1'b1;
        offer(32'h200);
        cycle();
        bus.if_en_i = 1'b0;
        run(2);
        bus.en = 1'b0;
        run(3);
        bus.en = 1'b1;
        run(20);
        chk("stall_sat", bus.stall_cnt_o, CNT_MAX);

        // Randomized traffic
        accepted = 1'b1;
        bus.if_en_i = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!bus.if_en_i || accepted) begin
                if ($urandom_range(0, 99) < 70) begin
                    offer(next_pc);
                    next_pc += 4;
                end else begin
                    bus.if_en_i = 1'b0;
                end
            end
            bus.en         = ($urandom_range(0, 99) < 90);
            bus.flush_i    = ($urandom_range(0, 99) < 4);
            bus.rob_full_i = ($urandom_range(0, 99) < 25);
            bus.rs_full_i  = ($urandom_range(0, 99) < 30);
            bus.lsb_full_i = ($urandom_range(0, 99) < 30);
            bus.dec_tp_i   = 2'($urandom_range(0, 3));
            cycle();
        end
        bus.en = 1'b1; bus.flush_i = 1'b0; bus.rs_full_i = 1'b0; bus.lsb_full_i = 1'b0;

        // Asynchronous reset while held
        bus.dec_tp_i   = TP_ALU;
        bus.rob_full_i = 1'b1;
        offer(32'h300);
        for (int k = 0; k < 4 && !accepted; k++) cycle();
        bus.if_en_i = 1'b0;
        run(2);
        chk("pre_rst_hold", dut.state, ST_HOLD);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_dec_en", bus.dec_en_o,    0);
        chk("arst_rdy",    bus.if_rdy_o,    0);
        chk("arst_stall",  bus.stall_cnt_o, 0);
        chk("arst_pc",     bus.dec_pc_o,    0);
        chk("arst_cnt",    dut.fifo_cnt,    0);
        chk("arst_state",  dut.state,       ST_RUN);
        q.delete();
        stall_m  = 0;
        in_flush = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.rob_full_i = 1'b0;
        offer(32'h400);
        cycle();
        bus.if_en_i = 1'b0;
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
